// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and helpers for the 4-channel ADC interleave sequencer.
//   seq_state_e : sequencer FSM states (StIdle/StRun/StDrain)
//   CH_W/NUM_CH : channel index width and channel count (fixed at 4)
//   next_ch()   : next enabled channel strictly above cur (ascending, wrapping), plus wrap flag
package adc_seq_pkg;

   localparam int CH_W   = 2;
   localparam int NUM_CH = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2
   } seq_state_e;

   // Returns {wrap, next}. Scanning offsets 1..NUM_CH means the current channel itself is
   // considered last, so a single-channel mask returns cur with wrap set.
   function automatic logic [CH_W:0] next_ch(input logic [CH_W-1:0] cur,
                                             input logic [NUM_CH-1:0] mask);
      logic [CH_W-1:0] idx;
      logic [CH_W-1:0] nxt;
      logic            found;
      nxt   = cur;
      found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = cur + CH_W'(i);
         if (!found && mask[idx]) begin
            nxt   = idx;
            found = 1'b1;
         end
      end
      return {(nxt <= cur), nxt};
   endfunction

endpackage

// File: rtl/adc_interleave_seq_if.sv
// adc_interleave_seq_if: control and sample-qualification bundle of the interleave sequencer.
//   enable/ch_mask/dwell            : requests from the controlling side
//   x_adc_select                    : registered 4:1 mux select
//   x_adc_valid/x_adc_ch/frame_done : sample strobe, channel tag, end-of-rotation marker
//   busy                            : sequencer in RUN or DRAIN
//   frame_cnt                       : rotation counter, present only with ADC_SEQ_FRAME_CNT_EN
// modport master = controller/consumer side, modport slave = sequencer side.
interface adc_interleave_seq_if #(
   parameter int unsigned DWELL_W = 8
);
   import adc_seq_pkg::*;

   logic               enable;
   logic [NUM_CH-1:0]  ch_mask;
   logic [DWELL_W-1:0] dwell;
   logic [CH_W-1:0]    x_adc_select;
   logic               x_adc_valid;
   logic [CH_W-1:0]    x_adc_ch;
   logic               frame_done;
   logic               busy;
`ifdef ADC_SEQ_FRAME_CNT_EN
   logic [15:0]        frame_cnt;

   modport master (output enable, ch_mask, dwell,
                   input  x_adc_select, x_adc_valid, x_adc_ch, frame_done, busy, frame_cnt);
   modport slave  (input  enable, ch_mask, dwell,
                   output x_adc_select, x_adc_valid, x_adc_ch, frame_done, busy, frame_cnt);
`else
   modport master (output enable, ch_mask, dwell,
                   input  x_adc_select, x_adc_valid, x_adc_ch, frame_done, busy);
   modport slave  (input  enable, ch_mask, dwell,
                   output x_adc_select, x_adc_valid, x_adc_ch, frame_done, busy);
`endif

endinterface

// File: rtl/adc_ch_rotator.sv
// adc_ch_rotator: combinational next-enabled-channel finder.
//   cur_i  : current channel index
//   mask_i : enabled-channel mask
//   next_o : next enabled channel strictly above cur_i, wrapping 3->0
//   wrap_o : 1 when next_o <= cur_i (rotation restarts)
module adc_ch_rotator
   import adc_seq_pkg::*;
(
   input  logic [CH_W-1:0]   cur_i,
   input  logic [NUM_CH-1:0] mask_i,
   output logic [CH_W-1:0]   next_o,
   output logic              wrap_o
);

   always_comb begin
      {wrap_o, next_o} = next_ch(cur_i, mask_i);
   end

endmodule

// File: rtl/adc_interleave_seq.sv
// adc_interleave_seq: channel sequencer for the 1-cycle-latency 4:1 x_adc mux.
//   clk         : system clock
//   GlobalReset : asynchronous active-low reset
//   bus         : adc_interleave_seq_if slave (enable/ch_mask/dwell in; select, strobes, busy out)
// Optional: define ADC_SEQ_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module adc_interleave_seq
   import adc_seq_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
) (
   input  logic                 clk,
   input  logic                 GlobalReset,
   adc_interleave_seq_if.slave  bus
);

   seq_state_e         state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [CH_W-1:0]    sel_q, sel_d;
   logic               valid_q, valid_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic               frame_q, frame_d;
   logic               busy_q, busy_d;
   logic [CH_W-1:0]    rot_cur, rot_next;
   logic               rot_wrap;
`ifdef ADC_SEQ_FRAME_CNT_EN
   logic [15:0]        frame_cnt_q, frame_cnt_d;
`endif

   // From IDLE, searching above channel 3 yields the lowest enabled channel.
   assign rot_cur = (state_q == StIdle) ? CH_W'(NUM_CH - 1) : sel_q;

   adc_ch_rotator u_rotator (
      .cur_i  (rot_cur),
      .mask_i (bus.ch_mask),
      .next_o (rot_next),
      .wrap_o (rot_wrap)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dwell_d = dwell_q;
      sel_d   = sel_q;
      valid_d = 1'b0;
      ch_d    = ch_q;
      frame_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.enable && (bus.ch_mask != '0)) begin
               state_d = StRun;
               sel_d   = rot_next;
               cnt_d   = '0;
               dwell_d = bus.dwell;
            end
         end
         StRun: begin
            if (cnt_q == dwell_q) begin
               valid_d = 1'b1;
               ch_d    = sel_q;
               cnt_d   = '0;
               dwell_d = bus.dwell;
               if (bus.enable && (bus.ch_mask != '0)) begin
                  sel_d   = rot_next;
                  frame_d = rot_wrap;
               end else begin
                  state_d = StDrain;
               end
            end else begin
               cnt_d = cnt_q + DWELL_W'(1);
            end
         end
         StDrain: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
`ifdef ADC_SEQ_FRAME_CNT_EN
      frame_cnt_d = frame_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         dwell_q <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         ch_q    <= '0;
         frame_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef ADC_SEQ_FRAME_CNT_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dwell_q <= dwell_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         ch_q    <= ch_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
`ifdef ADC_SEQ_FRAME_CNT_EN
         frame_cnt_q <= frame_cnt_d;
`endif
      end
   end

   assign bus.x_adc_select = sel_q;
   assign bus.x_adc_valid  = valid_q;
   assign bus.x_adc_ch     = ch_q;
   assign bus.frame_done   = frame_q;
   assign bus.busy         = busy_q;
`ifdef ADC_SEQ_FRAME_CNT_EN
   assign bus.frame_cnt    = frame_cnt_q;
`endif

endmodule

// File: tb/tb_adc_interleave_seq.sv
// tb_adc_interleave_seq: scoreboard bench for adc_interleave_seq. Expected {ch, frame_done}
// pairs are queued as each scenario is set up; a negedge monitor pops one per x_adc_valid.
module tb_adc_interleave_seq;

   typedef struct packed {
      logic [1:0] ch;
      logic       frame;
   } exp_t;

   logic clk = 1'b0;
   logic GlobalReset = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   adc_interleave_seq_if #(.DWELL_W(8)) bus ();

   adc_interleave_seq #(.DWELL_W(8)) dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [1:0] ch, input logic frame);
      exp_t e;
      e.ch    = ch;
      e.frame = frame;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.busy; i++) tick();
      check_eq("idle_reached", {31'd0, bus.busy}, 32'd0);
      check_eq("sb_empty", exp_q.size(), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_sel"},   {30'd0, bus.x_adc_select}, 32'd0);
      check_eq({tag, "_valid"}, {31'd0, bus.x_adc_valid}, 32'd0);
      check_eq({tag, "_ch"},    {30'd0, bus.x_adc_ch}, 32'd0);
      check_eq({tag, "_frame"}, {31'd0, bus.frame_done}, 32'd0);
      check_eq({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (GlobalReset) begin
         if (bus.frame_done && !bus.x_adc_valid) check_eq("frame_without_valid", 32'd1, 32'd0);
         if (bus.x_adc_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_valid", {30'd0, bus.x_adc_ch}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check_eq("valid_ch", {30'd0, bus.x_adc_ch}, {30'd0, e.ch});
               check_eq("frame_done", {31'd0, bus.frame_done}, {31'd0, e.frame});
            end
         end
      end
   end

   initial begin
      bus.enable  = 1'b0;
      bus.ch_mask = 4'b0000;
      bus.dwell   = 8'd0;
      repeat (3) tick();
      check_outputs_zero("reset");
      GlobalReset = 1'b1;
      tick();

      // Full mask, dwell=0: one channel per cycle; the drain boundary carries no frame_done.
      for (int k = 0; k < 8; k++) push(2'(k % 4), (k == 3));
      bus.ch_mask = 4'b1111;
      bus.dwell   = 8'd0;
      bus.enable  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("full_sel", {30'd0, bus.x_adc_select}, 32'(i % 4));
         check_eq("full_valid", {31'd0, bus.x_adc_valid}, {31'd0, (i >= 1)});
         check_eq("full_busy", {31'd0, bus.busy}, 32'd1);
      end
      bus.enable = 1'b0;
      wait_idle();
`ifdef ADC_SEQ_FRAME_CNT_EN
      check_eq("frame_cnt", {16'd0, bus.frame_cnt}, 32'd1);
`endif

      // Sparse mask 1010, dwell=2: select 1 x3, 3 x3, repeating.
      push(2'd1, 1'b0);
      push(2'd3, 1'b1);
      push(2'd1, 1'b0);
      push(2'd3, 1'b0);
      bus.ch_mask = 4'b1010;
      bus.dwell   = 8'd2;
      bus.enable  = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check_eq("sparse_sel", {30'd0, bus.x_adc_select}, ((i / 3) % 2 == 1) ? 32'd3 : 32'd1);
         check_eq("sparse_valid", {31'd0, bus.x_adc_valid}, {31'd0, (i > 0 && i % 3 == 0)});
      end
      bus.enable = 1'b0;
      wait_idle();

      // Stop mid-dwell: dwell=3, enable dropped one cycle into channel 1's dwell.
      push(2'd0, 1'b0);
      push(2'd1, 1'b0);
      bus.ch_mask = 4'b1111;
      bus.dwell   = 8'd3;
      bus.enable  = 1'b1;
      repeat (6) tick();
      bus.enable = 1'b0;
      repeat (2) tick();
      check_eq("stop_no_early_valid", {31'd0, bus.x_adc_valid}, 32'd0);
      tick();
      check_eq("stop_last_valid", {31'd0, bus.x_adc_valid}, 32'd1);
      check_eq("stop_drain_busy", {31'd0, bus.busy}, 32'd1);
      tick();
      check_eq("stop_idle_busy", {31'd0, bus.busy}, 32'd0);
      check_eq("stop_idle_valid", {31'd0, bus.x_adc_valid}, 32'd0);
      repeat (4) tick();
      check_eq("stop_sb_empty", exp_q.size(), 32'd0);

      // Single channel: select stays 2, frame_done on every non-drain valid.
      for (int k = 0; k < 4; k++) push(2'd2, 1'b1);
      push(2'd2, 1'b0);
      bus.ch_mask = 4'b0100;
      bus.dwell   = 8'd0;
      bus.enable  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("single_sel", {30'd0, bus.x_adc_select}, 32'd2);
      end
      bus.enable = 1'b0;
      wait_idle();

      // Empty mask: stays idle with enable high; select holds.
      bus.ch_mask = 4'b0000;
      bus.enable  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("empty_busy", {31'd0, bus.busy}, 32'd0);
         check_eq("empty_valid", {31'd0, bus.x_adc_valid}, 32'd0);
         check_eq("empty_sel_hold", {30'd0, bus.x_adc_select}, 32'd2);
      end
      bus.enable = 1'b0;
      tick();

      // Async reset during RUN, one cycle before a pending boundary.
      push(2'd0, 1'b0);
      bus.ch_mask = 4'b1111;
      bus.dwell   = 8'd1;
      bus.enable  = 1'b1;
      repeat (4) tick();
      check_eq("pre_reset_sel", {30'd0, bus.x_adc_select}, 32'd1);
      #2 GlobalReset = 1'b0;
      #1 check_outputs_zero("async_reset");
      repeat (2) tick();
      check_eq("reset_sb_empty", exp_q.size(), 32'd0);
      push(2'd2, 1'b0);
      bus.ch_mask = 4'b1100;
      GlobalReset = 1'b1;
      tick();
      check_eq("restart_sel", {30'd0, bus.x_adc_select}, 32'd2);
      check_eq("restart_busy", {31'd0, bus.busy}, 32'd1);
      bus.enable = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
